// File: rtl/bram_row_loader.sv
// bram_row_loader: packs a valid/ready stream of IN_W-bit words into
// DATA_W-bit rows and writes ROWS rows through one BRAM port from BASE_ADDR.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               1-cycle pulse, begins a run from IDLE or DONE
//   in_data, in_valid   input stream word and its valid
//   in_ready            loader accepts in_data this cycle (FILL only)
//   addr_o, ena_o, we_o BRAM address, enable and write enable
//   din_o               BRAM write data (registered row buffer)
//   busy, done          run in progress / run complete
module bram_row_loader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 1280,
    parameter int IN_W      = 32,
    parameter int ROWS      = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ena_o,
    output logic              we_o,
    output logic [DATA_W-1:0] din_o,
    output logic              busy,
    output logic              done
);

    localparam int WORDS = DATA_W / IN_W;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [WCW-1:0]    LAST_WORD = WCW'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    if ((DATA_W % IN_W) != 0 || WORDS < 1 || ROWS < 1 ||
        longint'(ROWS) > (longint'(1) << ADDR_W)) begin : g_bad_params
        $fatal(1, "bram_row_loader: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WCW-1:0]    word_cnt;
    logic [ADDR_W-1:0] row_cnt;
    logic              accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ena_o     = 1'b0;
        we_o      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && word_cnt == LAST_WORD) state_nxt = WRITE;
            end
            WRITE: begin
                ena_o     = 1'b1;
                we_o      = 1'b1;
                busy      = 1'b1;
                state_nxt = (row_cnt == LAST_ROW) ? DONE : FILL;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Row buffer doubles as din_o; stale words from the previous row are
    // simply overwritten as the new row fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o   <= BASE;
            din_o    <= '0;
            word_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        word_cnt <= '0;
                        row_cnt  <= '0;
                        addr_o   <= BASE;
                    end
                end
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < WORDS; k++) begin
                            if (word_cnt == WCW'(k)) begin
                                din_o[k*IN_W +: IN_W] <= in_data;
                            end
                        end
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (row_cnt != LAST_ROW) begin
                        row_cnt  <= row_cnt + 1'b1;
                        addr_o   <= addr_o + 1'b1;
                        word_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_row_loader.sv
// tb_bram_row_loader: directed bench for bram_row_loader with ROWS=3 and
// BASE_ADDR=4094 so every run also crosses the address wrap.
module tb_bram_row_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 1280;
    localparam int IN_W   = 32;
    localparam int WORDS  = DATA_W / IN_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr_o;
    logic              ena_o;
    logic              we_o;
    logic [DATA_W-1:0] din_o;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    bram_row_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .IN_W     (IN_W),
        .ROWS     (3),
        .BASE_ADDR(4094)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .addr_o  (addr_o),
        .ena_o   (ena_o),
        .we_o    (we_o),
        .din_o   (din_o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ena_o) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [DATA_W-1:0] exp);
        int bad_k;
        bad_k = -1;
        for (int k = WORDS - 1; k >= 0; k--) begin
            if (din_o[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) bad_k = k;
        end
        if (bad_k < 0) bad_k = 0;
        n_cmp++;
        assert (din_o === exp)
        else begin
            n_bad++;
            $error("FAIL %s: word %0d observed %0h expected %0h", tag, bad_k,
                   din_o[bad_k*IN_W +: IN_W], exp[bad_k*IN_W +: IN_W]);
        end
    endtask

    function automatic logic [IN_W-1:0] word(input int tag, input int row,
                                             input int k);
        return IN_W'(tag * 65536 + row * 256 + k);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done", 64'(done), 64'd0);
        chk("start_ready", 64'(in_ready), 64'd1);
        chk("start_addr", 64'(addr_o), 64'd4094);
    endtask

    // Feeds words 0..upto-1 of a row; when the row is complete, checks the
    // write cycle that must follow the last accepted word.
    task automatic feed_row(input int tag, input int row, input bit gappy,
                            input int poke, input int upto,
                            input int exp_addr);
        logic [DATA_W-1:0] exp;
        int n;
        exp = '0;
        for (int k = 0; k < upto; k++) begin
            if (gappy && (k % 2) == 1) begin
                in_valid = 1'b0;
                in_data  = 32'hdead_beef;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = word(tag, row, k);
            exp[k*IN_W +: IN_W] = in_data;
            start = (k == poke);
            n = 0;
            while (!in_ready && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!in_ready) chk("ready_wait", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (upto == WORDS) begin
            chk("wr_ena", 64'(ena_o), 64'd1);
            chk("wr_we", 64'(we_o), 64'd1);
            chk("wr_ready", 64'(in_ready), 64'd0);
            chk("wr_busy", 64'(busy), 64'd1);
            chk("wr_addr", 64'(addr_o), 64'(exp_addr));
            chk_row("wr_row", exp);
            @(posedge clk);
            #1;
            chk("post_wr_ena", 64'(ena_o), 64'd0);
        end
    endtask

    task automatic chk_done();
        chk("done_flag", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_ready", 64'(in_ready), 64'd0);
        chk("done_we", 64'(we_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", 64'(done), 64'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_ena", 64'(ena_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd4094);
        chk_row("rst_din", '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 64'(in_ready), 64'd0);

        // Run 1: row 0 with a stray start at word 10, row 1 gappy, wrap.
        pulse_start();
        feed_row(1, 0, 1'b0, 10, WORDS, 4094);
        feed_row(1, 1, 1'b1, -1, WORDS, 4095);
        feed_row(1, 2, 1'b0, -1, WORDS, 0);
        chk_done();
        chk("run1_writes", 64'(wr_cnt), 64'd3);

        // Run 2: restart from DONE, identical data and addresses.
        pulse_start();
        feed_row(1, 0, 1'b0, -1, WORDS, 4094);
        feed_row(1, 1, 1'b0, -1, WORDS, 4095);
        feed_row(1, 2, 1'b0, -1, WORDS, 0);
        chk_done();
        chk("run2_writes", 64'(wr_cnt), 64'd6);

        // Run 3: reset asynchronously at word 20 of row 1.
        pulse_start();
        feed_row(3, 0, 1'b0, -1, WORDS, 4094);
        feed_row(3, 1, 1'b0, -1, 20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        chk("arst_ena", 64'(ena_o), 64'd0);
        chk("arst_addr", 64'(addr_o), 64'd4094);
        chk_row("arst_din", '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_writes", 64'(wr_cnt), 64'd7);
        chk("arst_idle_busy", 64'(busy), 64'd0);

        pulse_start();
        feed_row(4, 0, 1'b0, -1, WORDS, 4094);
        chk("rerun_writes", 64'(wr_cnt), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
